// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encodings, the STATE
// port width and the cycle-counter width helper.
package reset_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    // One spare bit above clog2(max) so terminal counts never alias to zero.
    function automatic int calc_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// WIDTH-bit, STAGES-deep flop synchroniser for asynchronous level inputs;
// every stage resets asynchronously to 0.
module reset_seq_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: hold, wait for PLL lock, staggered per-channel
// release. Define RESET_SEQ_TIMEOUT_EN to enable the WAIT_LOCK timeout/retry.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH              = 4,
    parameter int SYNC_STAGES         = 3,
    parameter int HOLD_CYCLES         = 16,
    parameter int STAGGER_CYCLES      = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 1024
) (
    input  logic               SYS_CLK,
    input  logic               RESET_N,
    input  logic [NUM_CH-1:0]  LOCK_IN,
    input  logic [NUM_CH-1:0]  CH_MASK,
    input  logic               SW_RST_REQ,
    input  logic               STICKY_CLR,
    output logic [NUM_CH-1:0]  RST_N_OUT,
    output logic               ALL_READY,
    output logic [STATE_W-1:0] STATE,
    output logic               LOCK_LOSS,
    output logic               TIMEOUT_FLAG
);

    localparam int CNT_W = calc_cnt_w(HOLD_CYCLES, STAGGER_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CH - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] rst_n_out_q, rst_n_out_d;
    logic              all_ready_q, all_ready_d;
    logic              lock_loss_q, lock_loss_d;
    logic [NUM_CH-1:0] lock_sync;
    logic              lock_ok;
    logic              go_hold;
    logic              loss_evt;
    logic              timeout_evt;

    reset_seq_sync #(
        .WIDTH  (NUM_CH),
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk      (SYS_CLK),
        .rst_n    (RESET_N),
        .async_in (LOCK_IN),
        .sync_out (lock_sync)
    );

    // Masked channels count as locked so they never stall the sequence.
    assign lock_ok = &(lock_sync | ~CH_MASK);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rst_n_out_d = rst_n_out_q;
        all_ready_d = all_ready_q;
        go_hold     = 1'b0;
        loss_evt    = 1'b0;
        timeout_evt = 1'b0;

        case (state_q)
            ST_HOLD: begin
                rst_n_out_d = '0;
                all_ready_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_evt = 1'b1;
                    go_hold     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_RELEASE: begin
                if (!lock_ok) begin
                    loss_evt = 1'b1;
                    go_hold  = 1'b1;
                end else if (cnt_q == STAGGER_LAST) begin
                    // A masked channel burns its slot but its output stays low.
                    rst_n_out_d[idx_q] = CH_MASK[idx_q];
                    cnt_d              = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d     = ST_RUN;
                        all_ready_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (!lock_ok) begin
                    loss_evt = 1'b1;
                    go_hold  = 1'b1;
                end
            end
        endcase

        // Software request outranks everything but still lets loss_evt stand.
        if (go_hold || SW_RST_REQ) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            rst_n_out_d = '0;
            all_ready_d = 1'b0;
        end

        lock_loss_d = loss_evt | (lock_loss_q & ~STICKY_CLR);
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_n_out_q <= '0;
            all_ready_q <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rst_n_out_q <= rst_n_out_d;
            all_ready_q <= all_ready_d;
            lock_loss_q <= lock_loss_d;
        end
    end

`ifdef RESET_SEQ_TIMEOUT_EN
    logic timeout_q, timeout_d;

    always_comb begin
        timeout_d = timeout_evt | (timeout_q & ~STICKY_CLR);
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT_FLAG = timeout_q;
`else
    assign TIMEOUT_FLAG = 1'b0;
`endif

    assign RST_N_OUT = rst_n_out_q;
    assign ALL_READY = all_ready_q;
    assign STATE     = state_q;
    assign LOCK_LOSS = lock_loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: an elapsed-time reference model pushes
// per-edge expectations, a monitor pops and compares them on the falling edge.
module tb_reset_sequencer;

    localparam int NUM_CH              = 4;
    localparam int SYNC_STAGES         = 3;
    localparam int HOLD_CYCLES         = 16;
    localparam int STAGGER_CYCLES      = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 32;

    logic              SYS_CLK    = 1'b0;
    logic              RESET_N    = 1'b0;
    logic [NUM_CH-1:0] LOCK_IN    = '0;
    logic [NUM_CH-1:0] CH_MASK    = '1;
    logic              SW_RST_REQ = 1'b0;
    logic              STICKY_CLR = 1'b0;
    logic [NUM_CH-1:0] RST_N_OUT;
    logic              ALL_READY;
    logic [1:0]        STATE;
    logic              LOCK_LOSS;
    logic              TIMEOUT_FLAG;

    reset_sequencer #(
        .NUM_CH              (NUM_CH),
        .SYNC_STAGES         (SYNC_STAGES),
        .HOLD_CYCLES         (HOLD_CYCLES),
        .STAGGER_CYCLES      (STAGGER_CYCLES),
        .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES)
    ) dut (
        .SYS_CLK      (SYS_CLK),
        .RESET_N      (RESET_N),
        .LOCK_IN      (LOCK_IN),
        .CH_MASK      (CH_MASK),
        .SW_RST_REQ   (SW_RST_REQ),
        .STICKY_CLR   (STICKY_CLR),
        .RST_N_OUT    (RST_N_OUT),
        .ALL_READY    (ALL_READY),
        .STATE        (STATE),
        .LOCK_LOSS    (LOCK_LOSS),
        .TIMEOUT_FLAG (TIMEOUT_FLAG)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct packed {
        logic [NUM_CH-1:0] rst;
        logic              ready;
        logic [1:0]        state;
        logic              loss;
        logic              tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model: phase (0 hold, 1 wait, 2 release, 3 run) plus edges spent in it.
    int                m_state;
    int                m_elapsed;
    bit                m_loss;
    bit                m_tmo;
    logic [NUM_CH-1:0] m_hist [SYNC_STAGES];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state   = 0;
        m_elapsed = 0;
        m_loss    = 1'b0;
        m_tmo     = 1'b0;
        for (int j = 0; j < SYNC_STAGES; j++) m_hist[j] = '0;
    endfunction

    function automatic exp_t model_edge();
        logic [NUM_CH-1:0] lsync;
        bit   lock_ok, loss_evt, tmo_evt;
        int   n;
        exp_t e;
        lsync = m_hist[SYNC_STAGES-1];
        for (int j = SYNC_STAGES - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = LOCK_IN;
        lock_ok  = &(lsync | ~CH_MASK);
        loss_evt = 1'b0;
        tmo_evt  = 1'b0;
        m_elapsed++;
        case (m_state)
            0: if (m_elapsed == HOLD_CYCLES) begin m_state = 1; m_elapsed = 0; end
            1: begin
                if (lock_ok) begin
                    m_state = 2; m_elapsed = 0;
                end
`ifdef RESET_SEQ_TIMEOUT_EN
                else if (m_elapsed == LOCK_TIMEOUT_CYCLES) begin
                    m_state = 0; m_elapsed = 0; tmo_evt = 1'b1;
                end
`endif
            end
            2: begin
                if (!lock_ok) begin
                    m_state = 0; m_elapsed = 0; loss_evt = 1'b1;
                end else if (m_elapsed == STAGGER_CYCLES * NUM_CH) begin
                    m_state = 3; m_elapsed = 0;
                end
            end
            default: if (!lock_ok) begin m_state = 0; m_elapsed = 0; loss_evt = 1'b1; end
        endcase
        if (SW_RST_REQ) begin m_state = 0; m_elapsed = 0; end
        m_loss = loss_evt | (m_loss & !STICKY_CLR);
        m_tmo  = tmo_evt | (m_tmo & !STICKY_CLR);
        e.state = m_state[1:0];
        e.loss  = m_loss;
        e.tmo   = m_tmo;
        e.ready = (m_state == 3);
        if (m_state == 2) begin
            n     = m_elapsed / STAGGER_CYCLES;
            e.rst = CH_MASK & NUM_CH'((1 << n) - 1);
        end else if (m_state == 3) begin
            e.rst = CH_MASK;
        end else begin
            e.rst = '0;
        end
        return e;
    endfunction

    // Called just after a falling edge; drives inputs for the next rising edge.
    task automatic step(input bit sw, input bit clr);
        SW_RST_REQ = sw;
        STICKY_CLR = clr;
        exp_q.push_back(model_edge());
        @(negedge SYS_CLK);
        SW_RST_REQ = 1'b0;
        STICKY_CLR = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic run_until(input int st, input int el, input string name);
        int n;
        n = 0;
        while (!(m_state == st && m_elapsed == el) && n < 300) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: reached=0 required=1 (state %0d elapsed %0d)", name, st, el);
        end
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        exp_q.delete();
        RESET_N = 1'b0;
        #1;
        chk("reset_rst_n_out", 32'(RST_N_OUT), 32'h0);
        chk("reset_all_ready", 32'(ALL_READY), 32'h0);
        chk("reset_state", 32'(STATE), 32'h0);
        chk("reset_lock_loss", 32'(LOCK_LOSS), 32'h0);
        chk("reset_timeout", 32'(TIMEOUT_FLAG), 32'h0);
        model_reset();
        repeat (3) @(negedge SYS_CLK);
        RESET_N = 1'b1;
        mon_en  = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge SYS_CLK);
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rst_n_out", 32'(RST_N_OUT), 32'(e.rst));
                chk("all_ready", 32'(ALL_READY), 32'(e.ready));
                chk("state", 32'(STATE), 32'(e.state));
                chk("lock_loss", 32'(LOCK_LOSS), 32'(e.loss));
                chk("timeout_flag", 32'(TIMEOUT_FLAG), 32'(e.tmo));
            end
        end
    end

    initial begin : stimulus
        @(negedge SYS_CLK);
        LOCK_IN = '1;
        CH_MASK = '1;
        apply_reset();
        run(60);

        // Masked channel 2 with its lock low must not block the sequence.
        step(1'b1, 1'b0);
        CH_MASK = 4'b1011;
        LOCK_IN = 4'b1011;
        run(60);

        // Lock loss in RUN, then recovery.
        LOCK_IN = 4'b1001;
        run(8);
        LOCK_IN = 4'b1011;
        run(60);
        step(1'b0, 1'b1);

        // Software request on the edge that would release channel 1.
        step(1'b1, 1'b0);
        CH_MASK = '1;
        LOCK_IN = '1;
        run_until(2, 2 * STAGGER_CYCLES - 1, "reach_ch1_slot");
        step(1'b1, 1'b0);
        run(60);

        // Asynchronous reset in the middle of RELEASE.
        step(1'b1, 1'b0);
        run_until(2, 12, "reach_mid_release");
        #2;
        apply_reset();

        // No locks at all: timeout/retry with the macro, endless wait without.
        LOCK_IN = '0;
        run(110);
        step(1'b0, 1'b1);
        run(4);
        LOCK_IN = '1;
        run(60);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) LOCK_IN = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            else if ($urandom_range(0, 9) == 0) LOCK_IN = '1;
            if (m_state == 0 && $urandom_range(0, 9) == 0)
                CH_MASK = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
            step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
        end

        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
